// File: rtl/parking_gate_arbiter.sv
// Entry-gate arbiter for two parking floors: round-robin grants, a fixed-length
// gate-open window followed by a one-cycle guard, and per-floor occupancy counts.
module parking_gate_arbiter #(
  parameter int CAP0     = 5,
  parameter int CAP1     = 5,
  parameter int OPEN_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power,
  input  logic       req0,
  input  logic       req1,
  input  logic       exit0,
  input  logic       exit1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       deny0,
  output logic       deny1,
  output logic       gate_open,
  output logic [3:0] cnt0,
  output logic [3:0] cnt1,
  output logic       full0,
  output logic       full1
);

  typedef enum logic [1:0] {IDLE, OPEN, GUARD} state_t;

  state_t     state_reg;
  logic [7:0] timer_reg;
  logic       ptr_reg;
  logic [1:0] gnt_reg;
  logic [1:0] deny_reg;
  logic       gate_open_reg;

  logic [1:0] req_v;
  logic [1:0] exit_v;
  logic [1:0] full_v;
  logic [1:0] elig;
  logic [1:0] pick;
  logic       grant_en;

  assign req_v    = {req1, req0};
  assign exit_v   = {exit1, exit0};
  assign grant_en = (state_reg == IDLE) && power;

  // On a tie the floor that was not granted last wins; ptr_reg holds the last winner.
  always_comb begin
    elig = req_v & ~full_v;
    pick = 2'b00;
    if (grant_en) begin
      if (elig == 2'b11) begin
        pick = ptr_reg ? 2'b01 : 2'b10;
      end else begin
        pick = elig;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      ptr_reg       <= 1'b1;
      gnt_reg       <= '0;
      deny_reg      <= '0;
      gate_open_reg <= 1'b0;
    end else begin
      gnt_reg  <= pick;
      deny_reg <= grant_en ? (req_v & full_v) : 2'b00;
      case (state_reg)
        IDLE: begin
          if (pick != 2'b00) begin
            gate_open_reg <= 1'b1;
            timer_reg     <= 8'(OPEN_CYC - 1);
            ptr_reg       <= pick[1];
            state_reg     <= OPEN;
          end
        end
        OPEN: begin
          if (timer_reg == 8'd0) begin
            gate_open_reg <= 1'b0;
            state_reg     <= GUARD;
          end else begin
            timer_reg <= timer_reg - 8'd1;
          end
        end
        GUARD: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_floor
    localparam logic [3:0] CAP_G = (gi == 0) ? 4'(CAP0) : 4'(CAP1);
    logic [3:0] cnt_reg;
    logic       inc;
    logic       dec;

    assign inc        = pick[gi];
    assign dec        = exit_v[gi] && (cnt_reg != 4'd0);
    assign full_v[gi] = (cnt_reg == CAP_G);

    // Simultaneous entry and exit on the same floor cancel out.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= 4'd0;
      end else if (inc && !dec) begin
        cnt_reg <= cnt_reg + 4'd1;
      end else if (dec && !inc) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
    end
  end

  assign gnt0      = gnt_reg[0];
  assign gnt1      = gnt_reg[1];
  assign deny0     = deny_reg[0];
  assign deny1     = deny_reg[1];
  assign gate_open = gate_open_reg;
  assign cnt0      = g_floor[0].cnt_reg;
  assign cnt1      = g_floor[1].cnt_reg;
  assign full0     = full_v[0];
  assign full1     = full_v[1];

endmodule

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

Shares the single entry-gate actuator between the two floor code-entry units (floor 0 and floor 1) of the parking system. It grants the gate to one floor at a time with round-robin fairness, holds the gate open for a fixed number of cycles and tracks per-floor occupancy against capacity. Requests for a full floor are refused with a deny pulse. It sits between the per-floor code validators and the gate/LED/BCD display logic.

## Interface

- CAP0, default 5: floor 0 capacity, 1..15
- CAP1, default 5: floor 1 capacity, 1..15
- OPEN_CYC, default 8: gate-open duration in clk cycles, 2..255
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- power  in  1  system enable; 0 blocks new grants and denies
- req0, req1  in  1  entry request level from floor validator; held until gnt/deny seen, dropped the following cycle
- exit0, exit1  in  1  one-cycle pulse, car left that floor
- gnt0, gnt1  out  1  one-cycle grant pulse, registered
- deny0, deny1  out  1  one-cycle refusal pulse (floor full), registered
- gate_open  out  1  gate actuator drive, registered
- cnt0, cnt1  out  4  current occupancy per floor
- full0, full1  out  1  cntN == CAPN, combinational from registered count

## Operation

- Reset (rst=1 at an edge): state IDLE; gnt*, deny*, gate_open = 0; cnt0 = cnt1 = 0; timer = 0; last-granted pointer = 1 (floor 0 wins the first tie). Reset mid-OPEN closes the gate on the next edge and discards occupancy.
- States: IDLE, OPEN, GUARD.
- IDLE, power=1: eligibleN = reqN && !fullN.
  - Exactly one eligible: grant it.
  - Both eligible: grant the floor not equal to the last-granted pointer.
  - Grant at the edge: gntN=1, gate_open=1, cntN+1, pointer=N, timer=OPEN_CYC-1, state→OPEN.
  - reqN && fullN: denyN=1 for that edge only, no count change, state stays IDLE. A deny on one floor and a grant on the other may occur at the same edge.
- IDLE, power=0: requests ignored, no gnt/deny, state stays IDLE.
- OPEN: gate_open=1. Timer decrements each cycle. Requests are not sampled and are neither granted nor denied. At timer==0: gate_open=0, state→GUARD. power is ignored, so an open gate always completes its cycle.
- GUARD: one cycle with gate_open=0, then state→IDLE.
- Occupancy (every state, including during reset release):
  - exitN when cntN>0 decrements cntN. exitN when cntN==0 is ignored.
  - Grant and exitN at the same edge on the same floor: net no change.
  - The count never exceeds CAPN and never wraps.
- gnt*/deny* are low on every edge not described above.

## Timing

- Request seen in IDLE at cycle t: gnt/deny high in cycle t+1 (one-cycle latency).
- gate_open is high for exactly OPEN_CYC cycles, t+1 .. t+OPEN_CYC. GUARD occupies t+OPEN_CYC+1. IDLE samples at t+OPEN_CYC+2, so the earliest next grant is at t+OPEN_CYC+3.
- cntN updates in the same cycle gntN is high. fullN reflects the new count in that cycle, and a deny decision in IDLE uses the registered count.
- gnt0 and gnt1 are never high together. gntN and denyN for the same floor are never high together.

## Test plan

- Reset, power=1, req0 held at cycle 10 → gnt0=1 at cycle 11, gate_open high cycles 11–18 (OPEN_CYC=8), low at 19, cnt0=1.
- req0 and req1 both held continuously → grants alternate 0,1,0,1 with grant-to-grant spacing of OPEN_CYC+2 cycles; cnt0=cnt1=2 after four grants.
- CAP0=2: two floor-0 grants, then req0 → deny0 pulse one cycle later, no gate_open, cnt0 stays 2, full0=1. A following exit0 gives cnt0=1, full0=0, and the next req0 is granted.
- exit1 pulses with cnt1=0 → cnt1 stays 0. A grant to floor 1 coinciding with exit1 at cnt1=1 → cnt1 stays 1.
- power=0 with req1 held → no gnt/deny. Dropping power during OPEN → gate still open the full OPEN_CYC, then no new grant until power=1.
- rst asserted mid-OPEN → next cycle gate_open=0, cnt0=cnt1=0, state IDLE, and a simultaneous req0/req1 after release grants floor 0 first.
